pma_serializer: RTL and testbench
=================================

// Module: pma_serializer
// PURPOSE
//  - TX PMA serializer, directly downstream of the running-disparity FSM.
//  - Accepts 10-bit encoded words (Data_10/enable_PMA) through a one-word holding register.
//  - Shifts each word out LSB-first on a single serial line at bit rate.
//  - Marks word boundaries and flags underruns, so the upstream 8b/10b path can be paced and checked.
// PARAMETERS
//  WIDTH     10  bits per encoded word; bit counter runs 0..WIDTH-1
//  IDLE_BIT  0   level driven on TX_Out when idle or on underrun (idle word = {WIDTH{IDLE_BIT}})
// PORTS
//  Bit_Rate_Clk  in   1      serial bit-rate clock; all state on rising edge
//  Rst           in   1      asynchronous, active-high reset
//  Data_10       in   WIDTH  encoded word from RD FSM
//  Data_Valid    in   1      Data_10 valid this cycle
//  Data_Ready    out  1      holding register can accept a word this cycle
//  enable_PMA    in   1      1 = serialize, 0 = idle line
//  TX_Out        out  1      registered serial output
//  Word_Start    out  1      1 while TX_Out carries bit 0 of a word
//  Underrun      out  1      1-cycle pulse; idle word inserted for lack of data
// BEHAVIOUR
//  Reset (Rst=1) values:
//  - TX_Out=IDLE_BIT, Word_Start=0, Underrun=0, bit_cnt=0, state=IDLE.
//  - hold_valid=0, shreg={WIDTH{IDLE_BIT}}; held data is discarded.
//  - Data_Ready = 1 while Rst=1.
//  Handshake:
//  - Transfer occurs when Data_Valid & Data_Ready.
//  - Data_Ready = ~hold_valid | load_now (combinational).
//  - A word may be written in the same cycle the held word moves to the shifter.
//  States:
//  - IDLE: enable_PMA=0. bit_cnt held at 0, TX_Out<=IDLE_BIT, Word_Start<=0. The holding register still fills.
//  - SHIFT: enable_PMA=1. IDLE->SHIFT on the first cycle enable_PMA=1. SHIFT->IDLE on the first cycle enable_PMA=0.
//  Load cycle (SHIFT & bit_cnt==0, i.e. load_now):
//  - Source is the held word if hold_valid was set at cycle start, otherwise the idle word plus Underrun<=1.
//  - There is no bypass: a word written during a load cycle waits for the next boundary.
//  - Updates: TX_Out<=W[0], Word_Start<=1, shreg<=W>>1, bit_cnt<=1.
//  Other SHIFT cycles:
//  - TX_Out<=shreg[0], shreg<=shreg>>1, Word_Start<=0.
//  - bit_cnt increments and wraps WIDTH-1 -> 0, giving back-to-back words with no gap.
//  Latency: bit 0 of a word appears one clock after its load cycle; a word occupies exactly WIDTH consecutive clocks.
//  enable_PMA drop mid-word:
//  - The word is aborted; TX_Out=IDLE_BIT from the next cycle and bit_cnt<=0.
//  - The held word is retained and sent first after re-enable.
//  Reset mid-word: immediate abort to the reset values above; no partial word resumes.
//  Width rule: bit_cnt is $clog2(WIDTH) bits; WIDTH must be >= 2.
// CONFIGURATION
//  SER_PRBS7_EN defined:
//  - Adds input Prbs_Sel (1 bit) and a PRBS7 generator (x^7+x^6+1, seed 7'h7F).
//  - The generator advances once per SHIFT cycle.
//  - With Prbs_Sel=1, each load cycle takes WIDTH PRBS bits instead of the held word.
//  - Also with Prbs_Sel=1: the held word is not consumed, Data_Ready=~hold_valid, and Underrun stays 0.
//  - The generator is reset to its seed by Rst.
//  SER_PRBS7_EN undefined: the Prbs_Sel port and the generator do not exist; data path only.
// TESTING
//  1 Rst=1 mid-word -> next edge TX_Out=0, Word_Start=0, Underrun=0, Data_Ready=1; sequence restarts cleanly after release.
//  2 enable_PMA=1, one word 10'b0011111010 -> TX_Out 0,1,0,1,1,1,1,1,0,0 from the cycle after load; Word_Start on first bit only.
//  3 Words 10'h0FA, 10'h305 streamed with Data_Valid=1 -> 20 contiguous bits; Data_Ready=0 between boundaries when hold full.
//  4 No Data_Valid at a boundary -> 10 zero bits, Underrun=1 for 1 cycle alongside Word_Start; the next valid word is sent at the following boundary.
//  5 enable_PMA=0 after bit 4 of 10'h0FA, held 10'h305 -> TX_Out=0 next cycle; on re-enable 10'h305 is sent first with Word_Start.
//  6 SER_PRBS7_EN, Prbs_Sel=1 for 254 bits:
//    - Stream matches the x^7+x^6+1 model and repeats with period 127.
//    - Held word is untouched; Underrun stays 0.

Source files
------------

// File: rtl/pma_ser_if.sv
// Word/serial bundle between the RD FSM (master) and the TX PMA serializer (slave).
// Prbs_Sel exists only when SER_PRBS7_EN is defined.
interface pma_ser_if #(
   parameter int WIDTH = 10
);
   // Data_Valid/Data_Ready: a word transfers on every rising edge where both are high;
   // the master holds Data_10 stable while Data_Valid is high and Ready is low.
   logic [WIDTH-1:0] Data_10;
   logic             Data_Valid;
   logic             Data_Ready;
   logic             enable_PMA;
   logic             TX_Out;
   logic             Word_Start;
   logic             Underrun;
   logic             state_dbg;
`ifdef SER_PRBS7_EN
   logic             Prbs_Sel;

   modport master (
      output Data_10, Data_Valid, enable_PMA, Prbs_Sel,
      input  Data_Ready, TX_Out, Word_Start, Underrun, state_dbg
   );

   modport slave (
      input  Data_10, Data_Valid, enable_PMA, Prbs_Sel,
      output Data_Ready, TX_Out, Word_Start, Underrun, state_dbg
   );
`else
   modport master (
      output Data_10, Data_Valid, enable_PMA,
      input  Data_Ready, TX_Out, Word_Start, Underrun, state_dbg
   );

   modport slave (
      input  Data_10, Data_Valid, enable_PMA,
      output Data_Ready, TX_Out, Word_Start, Underrun, state_dbg
   );
`endif
endinterface

// File: rtl/pma_serializer.sv
// TX PMA serializer: one-word holding register feeding an LSB-first shifter at bit rate.
// Optional PRBS7 test source (x^7+x^6+1) is built when SER_PRBS7_EN is defined.
module pma_serializer #(
   parameter int WIDTH    = 10,
   parameter bit IDLE_BIT = 1'b0
) (
   input logic       Bit_Rate_Clk,
   input logic       Rst,
   pma_ser_if.slave  ser
);

   localparam int               CW        = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] IDLE_WORD = {WIDTH{IDLE_BIT}};
   localparam logic [CW-1:0]    CNT_LAST  = CW'(WIDTH - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic             hold_valid_q, hold_valid_d;
   logic             tx_q, tx_d;
   logic             ws_q, ws_d;
   logic             ur_q, ur_d;

   logic             load_now;
   logic             ready;
   logic             accept;
   logic             consume;
   logic [WIDTH-1:0] load_word;

`ifdef SER_PRBS7_EN
   logic [6:0]       prbs_q, prbs_d;
   logic [6:0]       prbs_walk;
   logic [WIDTH-1:0] prbs_word;
   logic             prbs_sel;

   assign prbs_sel = ser.Prbs_Sel;

   // A load takes the next WIDTH generator bits; the generator itself steps once per
   // bit, so consecutive PRBS words form one unbroken sequence on the line.
   always_comb begin
      prbs_walk = prbs_q;
      prbs_word = '0;
      for (int i = 0; i < WIDTH; i++) begin
         prbs_word[i] = prbs_walk[6] ^ prbs_walk[5];
         prbs_walk    = {prbs_walk[5:0], prbs_walk[6] ^ prbs_walk[5]};
      end
      prbs_d = ser.enable_PMA ? {prbs_q[5:0], prbs_q[6] ^ prbs_q[5]} : prbs_q;
   end
`endif

   assign load_now = ser.enable_PMA && (bit_cnt_q == '0);

`ifdef SER_PRBS7_EN
   assign ready   = prbs_sel ? ~hold_valid_q : (~hold_valid_q | load_now);
   assign consume = load_now && hold_valid_q && !prbs_sel;
`else
   assign ready   = ~hold_valid_q | load_now;
   assign consume = load_now && hold_valid_q;
`endif

   assign accept = ser.Data_Valid && ready;

   always_comb begin
      state_d      = ser.enable_PMA ? SHIFT : IDLE;
      bit_cnt_d    = bit_cnt_q;
      shreg_d      = shreg_q;
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      tx_d         = tx_q;
      ws_d         = 1'b0;
      ur_d         = 1'b0;
      load_word    = IDLE_WORD;

      // Clear before fill so a same-cycle write replaces the word leaving for the shifter.
      if (consume) begin
         hold_valid_d = 1'b0;
      end
      if (accept) begin
         hold_d       = ser.Data_10;
         hold_valid_d = 1'b1;
      end

      if (!ser.enable_PMA) begin
         bit_cnt_d = '0;
         tx_d      = IDLE_BIT;
         shreg_d   = IDLE_WORD;
      end else if (load_now) begin
`ifdef SER_PRBS7_EN
         if (prbs_sel) begin
            load_word = prbs_word;
         end else if (hold_valid_q) begin
            load_word = hold_q;
         end else begin
            ur_d = 1'b1;
         end
`else
         if (hold_valid_q) begin
            load_word = hold_q;
         end else begin
            ur_d = 1'b1;
         end
`endif
         tx_d      = load_word[0];
         ws_d      = 1'b1;
         shreg_d   = load_word >> 1;
         bit_cnt_d = CW'(1);
      end else begin
         tx_d      = shreg_q[0];
         shreg_d   = shreg_q >> 1;
         bit_cnt_d = (bit_cnt_q == CNT_LAST) ? '0 : bit_cnt_q + CW'(1);
      end
   end

   always_ff @(posedge Bit_Rate_Clk or posedge Rst) begin
      if (Rst) begin
         state_q      <= IDLE;
         bit_cnt_q    <= '0;
         shreg_q      <= IDLE_WORD;
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
         tx_q         <= IDLE_BIT;
         ws_q         <= 1'b0;
         ur_q         <= 1'b0;
`ifdef SER_PRBS7_EN
         prbs_q       <= 7'h7F;
`endif
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shreg_q      <= shreg_d;
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         tx_q         <= tx_d;
         ws_q         <= ws_d;
         ur_q         <= ur_d;
`ifdef SER_PRBS7_EN
         prbs_q       <= prbs_d;
`endif
      end
   end

   assign ser.Data_Ready = ready;
   assign ser.TX_Out     = tx_q;
   assign ser.Word_Start = ws_q;
   assign ser.Underrun   = ur_q;
   assign ser.state_dbg  = state_q;

endmodule

// File: tb/tb_pma_serializer.sv
// Bench for pma_serializer: vector table for reset/single-word/underrun timing, plus
// hand sequences for streaming, mid-word disable and (with SER_PRBS7_EN) the PRBS source.
module tb_pma_serializer;

   localparam int               W         = 10;
   localparam bit               IDLE_BIT  = 1'b0;
   localparam logic [W-1:0]     IDLE_WORD = {W{IDLE_BIT}};

   logic clk;
   logic rst;

   pma_ser_if #(.WIDTH(W)) bus ();

   pma_serializer #(.WIDTH(W), .IDLE_BIT(IDLE_BIT)) dut (
      .Bit_Rate_Clk (clk),
      .Rst          (rst),
      .ser          (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Scoreboard: words accepted by the DUT, popped when the line shows their bit 0.
   logic [W-1:0] exp_q[$];
   logic [W-1:0] cur_exp;
   int           cnt = 0;
   bit           prbs_mode = 1'b0;
   logic [6:0]   prbs_s;

   typedef struct {
      bit           r;
      bit           v;
      logic [W-1:0] d;
      bit           en;
      bit           rdy;
      bit           tx;
      bit           ws;
      bit           ur;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic void add(input bit r, input bit v, input logic [W-1:0] d, input bit en,
                               input bit rdy, input bit tx, input bit ws, input bit ur);
      vec_t t;
      t.r = r; t.v = v; t.d = d; t.en = en;
      t.rdy = rdy; t.tx = tx; t.ws = ws; t.ur = ur;
      vecs.push_back(t);
   endfunction

   // One bit period: drive at posedge+1, sample Ready at negedge, outputs at posedge+1.
   task automatic step(input bit r, input bit v, input logic [W-1:0] d, input bit en,
                       output bit rdy);
      int q_before;
      bit exp_ws;
      bit exp_ur;
      rst            = r;
      bus.Data_Valid = v;
      bus.Data_10    = d;
      bus.enable_PMA = en;
      @(negedge clk);
      rdy      = bus.Data_Ready;
      q_before = exp_q.size();
      if (!r && v && rdy) exp_q.push_back(d);
      @(posedge clk);
      #1;
      if (r) begin
         exp_q.delete();
         cnt = 0;
         check("rst_ready", rdy, 1);
         check("rst_tx", bus.TX_Out, IDLE_BIT);
         check("rst_ws", bus.Word_Start, 0);
         check("rst_ur", bus.Underrun, 0);
      end else if (!en) begin
         cnt = 0;
         check("idle_tx", bus.TX_Out, IDLE_BIT);
         check("idle_ws", bus.Word_Start, 0);
         check("idle_state", bus.state_dbg, 0);
`ifdef SER_PRBS7_EN
      end else if (prbs_mode) begin
         logic fb;
         fb     = prbs_s[6] ^ prbs_s[5];
         prbs_s = {prbs_s[5:0], fb};
         check("prbs_bit", bus.TX_Out, fb);
         check("prbs_ur", bus.Underrun, 0);
         check("prbs_ready", rdy, 0);
`endif
      end else begin
         exp_ws = (cnt == 0) || (cnt == W);
         check("word_start", bus.Word_Start, exp_ws);
         check("shift_state", bus.state_dbg, 1);
         if (exp_ws) begin
            exp_ur = (q_before == 0);
            check("underrun", bus.Underrun, exp_ur);
            if (exp_ur || exp_q.size() == 0) cur_exp = IDLE_WORD;
            else cur_exp = exp_q.pop_front();
            cnt = 0;
         end else begin
            check("underrun_mid", bus.Underrun, 0);
         end
         check($sformatf("tx_bit%0d", cnt), bus.TX_Out, cur_exp[cnt]);
         cnt++;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit rdy;
      rst            = 1'b1;
      bus.Data_Valid = 1'b0;
      bus.Data_10    = '0;
      bus.enable_PMA = 1'b0;
`ifdef SER_PRBS7_EN
      bus.Prbs_Sel   = 1'b0;
`endif
      @(posedge clk);
      #1;
      step(1, 0, '0, 0, rdy);
      step(1, 0, '0, 0, rdy);

      // Vector table: single word 0x0FA, underrun word, 0x305, reset mid-word, restart.
      add(0, 1, 10'h0FA, 0, 1, 0, 0, 0);
      add(0, 0, '0,      1, 1, 0, 1, 0);
      add(0, 0, '0,      1, 1, 1, 0, 0);
      add(0, 0, '0,      1, 1, 0, 0, 0);
      add(0, 0, '0,      1, 1, 1, 0, 0);
      add(0, 0, '0,      1, 1, 1, 0, 0);
      add(0, 0, '0,      1, 1, 1, 0, 0);
      add(0, 0, '0,      1, 1, 1, 0, 0);
      add(0, 0, '0,      1, 1, 1, 0, 0);
      add(0, 0, '0,      1, 1, 0, 0, 0);
      add(0, 0, '0,      1, 1, 0, 0, 0);
      add(0, 0, '0,      1, 1, 0, 1, 1);
      add(0, 1, 10'h305, 1, 1, 0, 0, 0);
      for (int i = 0; i < 8; i++) add(0, 0, '0, 1, 0, 0, 0, 0);
      add(0, 0, '0,      1, 1, 1, 1, 0);
      add(1, 0, '0,      1, 1, 0, 0, 0);
      add(0, 0, '0,      0, 1, 0, 0, 0);
      add(0, 1, 10'h305, 1, 1, 0, 1, 1);
      for (int i = 0; i < 9; i++) add(0, 0, '0, 1, 0, 0, 0, 0);
      add(0, 0, '0,      1, 1, 1, 1, 0);
      add(0, 0, '0,      0, 1, 0, 0, 0);

      foreach (vecs[i]) begin
         step(vecs[i].r, vecs[i].v, vecs[i].d, vecs[i].en, rdy);
         check($sformatf("vec%0d_rdy", i), rdy, vecs[i].rdy);
         check($sformatf("vec%0d_tx", i), bus.TX_Out, vecs[i].tx);
         check($sformatf("vec%0d_ws", i), bus.Word_Start, vecs[i].ws);
         check($sformatf("vec%0d_ur", i), bus.Underrun, vecs[i].ur);
      end

      // Streaming: 0x0FA, 0x305, 0x2AA back-to-back; Ready low while hold is full mid-word.
      step(0, 1, 10'h0FA, 0, rdy);
      check("stream_rdy_pre", rdy, 1);
      step(0, 1, 10'h305, 1, rdy);
      check("stream_rdy_load", rdy, 1);
      for (int i = 0; i < 9; i++) begin
         step(0, 1, 10'h2AA, 1, rdy);
         check("stream_rdy_full", rdy, 0);
      end
      step(0, 1, 10'h2AA, 1, rdy);
      check("stream_rdy_boundary", rdy, 1);
      for (int i = 0; i < 25; i++) step(0, 0, '0, 1, rdy);
      step(0, 0, '0, 0, rdy);
      check("stream_drained", exp_q.size(), 0);

      // Disable after bit 4 of 0x0FA with 0x305 held; 0x305 must lead after re-enable.
      step(0, 1, 10'h0FA, 0, rdy);
      step(0, 1, 10'h305, 1, rdy);
      check("abort_rdy_load", rdy, 1);
      for (int i = 0; i < 4; i++) step(0, 0, '0, 1, rdy);
      check("abort_bit4", bus.TX_Out, 1);
      step(0, 0, '0, 0, rdy);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, '0, 0, rdy);
         check("abort_hold_kept", rdy, 0);
      end
      step(0, 0, '0, 1, rdy);
      check("reenable_rdy", rdy, 1);
      check("reenable_ws", bus.Word_Start, 1);
      for (int i = 0; i < 9; i++) step(0, 0, '0, 1, rdy);
      step(0, 0, '0, 0, rdy);
      check("reenable_drained", exp_q.size(), 0);

`ifdef SER_PRBS7_EN
      // PRBS source from the reset seed; the held word must survive and then go out normally.
      step(1, 0, '0, 0, rdy);
      step(0, 1, 10'h155, 0, rdy);
      check("prbs_prefill_rdy", rdy, 1);
      bus.Prbs_Sel = 1'b1;
      prbs_mode    = 1'b1;
      prbs_s       = 7'h7F;
      for (int i = 0; i < 260; i++) step(0, 0, '0, 1, rdy);
      step(0, 0, '0, 0, rdy);
      bus.Prbs_Sel = 1'b0;
      prbs_mode    = 1'b0;
      for (int i = 0; i < 10; i++) step(0, 0, '0, 1, rdy);
      step(0, 0, '0, 0, rdy);
      check("prbs_hold_sent", exp_q.size(), 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
